lsu_mem_master: RTL and testbench
=================================

# lsu_mem_master

Load/store master that sits between the execute stage and the synchronous single-port data RAM. It accepts one load or store request at a time, generates word-aligned RAM reads and writes, performs read-modify-write for byte and halfword stores, and returns sign- or zero-extended load data. Illegal or misaligned requests return an error response and make no RAM access.

## Interface
- `MEM_AW`, default 10: RAM word-address width. The byte address `req_addr[MEM_AW+1:2]` selects the word.
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request. High only in IDLE.
- `req_load` in 1: request is a load.
- `req_store` in 1: request is a store.
- `req_funct` in 3: access type. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse. There is no response backpressure.
- `resp_rdata` out 32: extended load data. It is 0 for stores and errors.
- `resp_err` out 1: request was illegal or misaligned. Qualified by `resp_valid`.
- `mem_re` out 1: RAM read enable.
- `mem_we` out 1: RAM write enable, full word.
- `mem_addr` out MEM_AW: RAM word address.
- `mem_wdata` out 32: RAM write word.
- `mem_rdata` in 32: RAM read data, valid on the cycle after `mem_re`.

## Operation
- **States:** IDLE, RD, WAIT, WR, RESP.
- **IDLE:** `req_ready=1`. On `req_valid`, capture addr, funct, wdata and op, then decode:
  - Illegal if `req_load` and `req_store` are both 1, if both are 0, if a load funct is 011/110/111, or if a store funct is above 010. Illegal goes to RESP with err=1.
  - Misaligned if a half access has `addr[0]=1`, or a word access has `addr[1:0]≠0`. Misaligned goes to RESP with err=1 (see Configuration).
  - A load goes to RD.
  - SW goes to WR with the merged word set to wdata.
  - SB or SH goes to RD.
- **RD:** `mem_re=1`, `mem_addr` = captured word address. Next state is WAIT.
- **WAIT:** sample `mem_rdata`.
  - Load: extract the lane and register it to `resp_rdata`, then go to RESP.
  - Store: register the merged word, then go to WR.
- **WR:** `mem_we=1`, `mem_wdata` = merged word. Next state is RESP.
- **RESP:** `resp_valid=1`. Next state is IDLE. No new request is accepted in RESP.
- **Lane extract (loads):**
  - Byte = `mem_rdata[8*addr[1:0] +: 8]`.
  - Half = `mem_rdata[16*addr[1] +: 16]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- **Lane merge (stores):**
  - SB replaces byte lane `addr[1:0]` of the read word with `wdata[7:0]`.
  - SH replaces half lane `addr[1]` with `wdata[15:0]`.
  - Other lanes are preserved bit-exact.
- **Address wrap:** address bits above `MEM_AW+1` are ignored, so the address wraps modulo the RAM size.
- `mem_addr` and `mem_wdata` hold their last values outside RD/WR. They are don't-care when the enables are low.

## Timing
- **Latency** (request accepted at edge N; listed cycle is where `resp_valid` is high):
  - Load: N+3.
  - SW: N+2.
  - SB/SH: N+4.
  - Error: N+1.
- **Enables:** `mem_re`, `mem_we` and `resp_valid` are decoded from registered state, so they are glitch-free. Each is gated with `reset`, so none is asserted in a cycle where `reset=0`.
- **Reset values:**
  - state = IDLE.
  - `req_ready=1` after the first clock edge with `reset` high; it is 0 while `reset=0`.
  - `resp_valid=0`, `resp_err=0`, `resp_rdata=0`.
  - `mem_re=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
- **Reset mid-operation:** the transaction is abandoned with no response. A pending RMW write is not issued.
- **Back-to-back requests:** a new request is accepted in the cycle after RESP, at the earliest.
- **Input stability:** request inputs are sampled only on the accept edge and need not be held afterwards.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: misaligned accesses take the error path described above.
- Undefined:
  - Misalignment is not checked. Half accesses use `addr` with bit 0 cleared; word accesses use `addr` with bits 1:0 cleared.
  - The access proceeds normally.
  - `resp_err` is raised only for illegal requests.

## Structure
- **Shared `defines.v`:** load funct constants (`L_BYTE`, `L_HALF`, `L_WORD`, `L_BYTE_U`, `L_HALF_U`), store funct constants (`S_BYTE`, `S_HALF`, `S_WORD`), and the 3-bit state encodings.
- **Sub-module `lsu_lane_align`:** purely combinational. It takes (funct, addr[1:0], mem_rdata, wdata) and returns the extracted load value and the merged store word. The FSM lives in `lsu_mem_master`.

## Test plan
- **Store word then load bytes:**
  - SW 0xDEADBEEF to addr 0x10.
  - LB at 0x13 → resp_rdata 0xFFFFFFDE, err 0.
  - LBU at 0x10 → 0x000000EF.
- **Store halfword via RMW:**
  - Word 0x11223344 at 0x20.
  - SH 0xABCD to 0x22 → RAM word 0xABCD3344.
  - `mem_re` high at N+1, `mem_we` high at N+3, `resp_valid` at N+4.
- **Store byte:** SB 0x7F to 0x21 over 0xABCD3344 → RAM word 0xABCD7F44. LH at 0x20 → 0x00007F44.
- **Misaligned access:**
  - With `LSU_MISALIGN_TRAP_EN`: LW at 0x22 → `resp_valid` at N+1, err 1, `mem_re`/`mem_we` never asserted.
  - Without the macro: the same LW returns the word at 0x20, err 0.
- **Illegal request:** `req_load=req_store=1` → err 1 at N+1, no RAM access.
- **Reset mid-RMW:** SB accepted, `reset=0` asserted during WAIT → no `mem_we` pulse, no `resp_valid`, RAM word unchanged, `req_ready=1` one edge after reset releases.

Source files
------------

// File: rtl/lsu_mem_master_pkg.sv
// Shared definitions for the load/store master: funct encodings, FSM state
// encoding and small decode helpers used by lsu_mem_master and lsu_lane_align.
package lsu_mem_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } lsu_state_e;

    localparam logic [2:0] L_BYTE   = 3'b000;
    localparam logic [2:0] L_HALF   = 3'b001;
    localparam logic [2:0] L_WORD   = 3'b010;
    localparam logic [2:0] L_BYTE_U = 3'b100;
    localparam logic [2:0] L_HALF_U = 3'b101;
    localparam logic [2:0] S_BYTE   = 3'b000;
    localparam logic [2:0] S_HALF   = 3'b001;
    localparam logic [2:0] S_WORD   = 3'b010;

    function automatic logic funct_legal(input logic is_load, input logic [2:0] funct);
        if (is_load) begin
            return (funct == L_BYTE) || (funct == L_HALF) || (funct == L_WORD) ||
                   (funct == L_BYTE_U) || (funct == L_HALF_U);
        end
        return (funct == S_BYTE) || (funct == S_HALF) || (funct == S_WORD);
    endfunction

    // funct[1:0] gives the access size for both loads and stores.
    function automatic logic misaligned(input logic [2:0] funct, input logic [1:0] off);
        case (funct[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] align_off(input logic [2:0] funct, input logic [1:0] off);
        case (funct[1:0])
            2'b01:   return {off[1], 1'b0};
            2'b10:   return 2'b00;
            default: return off;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_master_lane_align.sv
// lsu_lane_align: combinational byte/half lane extraction for loads (with sign
// or zero extension) and read-modify-write lane merging for stores.
module lsu_lane_align
    import lsu_mem_master_pkg::*;
(
    input  logic [2:0]  funct,
    input  logic [1:0]  byte_off,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;

    always_comb begin
        lane_b = mem_rdata[{byte_off, 3'b000} +: 8];
        lane_h = mem_rdata[{byte_off[1], 4'b0000} +: 16];
        case (funct)
            L_BYTE:   load_data = {{24{lane_b[7]}}, lane_b};
            L_HALF:   load_data = {{16{lane_h[15]}}, lane_h};
            L_BYTE_U: load_data = {24'd0, lane_b};
            L_HALF_U: load_data = {16'd0, lane_h};
            default:  load_data = mem_rdata;
        endcase
    end

    // Lanes not addressed by the store keep the word read from RAM.
    always_comb begin
        store_word = mem_rdata;
        case (funct[1:0])
            2'b00:   store_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
            2'b01:   store_word[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store master between execute and a single-port synchronous data RAM.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned accesses into error responses.
module lsu_mem_master
    import lsu_mem_master_pkg::*;
#(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [2:0]        req_funct,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_re,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        funct_q, funct_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              load_q, load_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic              req_legal;
    logic              req_err;
    logic [1:0]        eff_off;
    logic [31:0]       lane_load;
    logic [31:0]       lane_store;
    logic              addr_hi_unused;

    // High address bits are dropped so accesses wrap modulo the RAM size.
    assign addr_hi_unused = ^req_addr[31:MEM_AW+2];

    always_comb begin
        req_legal = (req_load ^ req_store) && funct_legal(req_load, req_funct);
`ifdef LSU_MISALIGN_TRAP_EN
        req_err = !req_legal || misaligned(req_funct, req_addr[1:0]);
        eff_off = req_addr[1:0];
`else
        req_err = !req_legal;
        eff_off = align_off(req_funct, req_addr[1:0]);
`endif
    end

    lsu_lane_align u_lane_align (
        .funct      (funct_q),
        .byte_off   (off_q),
        .mem_rdata  (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (lane_load),
        .store_word (lane_store)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_err)                    state_d = ST_RESP;
                    else if (req_load)              state_d = ST_RD;
                    else if (req_funct == S_WORD)   state_d = ST_WR;
                    else                            state_d = ST_RD;
                end
            end
            ST_RD:   state_d = ST_WAIT;
            ST_WAIT: state_d = load_q ? ST_RESP : ST_WR;
            ST_WR:   state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Enables come straight from registered state, masked while reset is low.
    always_comb begin
        req_ready  = reset && (state_q == ST_IDLE);
        mem_re     = reset && (state_q == ST_RD);
        mem_we     = reset && (state_q == ST_WR);
        resp_valid = reset && (state_q == ST_RESP);
        mem_addr   = mem_addr_q;
        mem_wdata  = mem_wdata_q;
        resp_rdata = resp_rdata_q;
        resp_err   = resp_err_q;
    end

    always_comb begin
        off_d        = off_q;
        funct_d      = funct_q;
        wdata_d      = wdata_q;
        load_d       = load_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    off_d        = eff_off;
                    funct_d      = req_funct;
                    wdata_d      = req_wdata;
                    load_d       = req_load;
                    resp_err_d   = req_err;
                    resp_rdata_d = '0;
                    if (!req_err) begin
                        mem_addr_d = req_addr[MEM_AW+1:2];
                        if (req_store && (req_funct == S_WORD)) begin
                            mem_wdata_d = req_wdata;
                        end
                    end
                end
            end
            // mem_wdata doubles as the merged-word register for RMW stores.
            ST_WAIT: begin
                if (load_q) resp_rdata_d = lane_load;
                else        mem_wdata_d  = lane_store;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        off_q   <= off_d;
        funct_q <= funct_d;
        wdata_q <= wdata_d;
        load_q  <= load_d;
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: behavioural RAM, request-level reference model with
// per-cycle output comparison, and hand-computed literal expectations.
module tb_lsu_mem_master;

    localparam int MEM_AW = 10;
    localparam int DEPTH  = 1 << MEM_AW;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_load = 1'b0;
    logic              req_store = 1'b0;
    logic [2:0]        req_funct = 3'd0;
    logic [31:0]       req_addr = 32'd0;
    logic [31:0]       req_wdata = 32'd0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_re;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    always #5 clk = ~clk;

    lsu_mem_master #(.MEM_AW(MEM_AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_load   (req_load),
        .req_store  (req_store),
        .req_funct  (req_funct),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    logic [31:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model state: cycle numbers at which each event is due (-1 = none).
    int          t_acc = -1, e_re = -1, e_we = -1, e_resp = -1, e_idx = 0;
    logic [31:0] e_word = 32'd0, e_rd = 32'd0;
    logic        e_err = 1'b0;
    logic [31:0] shadow [DEPTH];
    bit          chk_en = 1'b0;
    int          resp_cnt = 0;
    logic [31:0] got_rd = 32'd0;
    logic        got_err = 1'b0;

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            if (!reset) begin
                chk("rst_req_ready", 32'(req_ready), 32'd0);
                chk("rst_mem_re", 32'(mem_re), 32'd0);
                chk("rst_mem_we", 32'(mem_we), 32'd0);
                chk("rst_resp_valid", 32'(resp_valid), 32'd0);
            end else begin
                chk("req_ready", 32'(req_ready),
                    32'(!(t_acc >= 0 && cyc >= t_acc && cyc <= e_resp)));
                chk("mem_re", 32'(mem_re), 32'(cyc == e_re));
                if (mem_re) chk("mem_addr_rd", 32'(mem_addr), 32'(e_idx));
                chk("mem_we", 32'(mem_we), 32'(cyc == e_we));
                if (mem_we) begin
                    chk("mem_addr_wr", 32'(mem_addr), 32'(e_idx));
                    chk("mem_wdata", mem_wdata, e_word);
                end
                if (cyc == e_we) shadow[e_idx] = e_word;
                chk("resp_valid", 32'(resp_valid), 32'(cyc == e_resp));
                if (resp_valid) begin
                    chk("resp_err", 32'(resp_err), 32'(e_err));
                    chk("resp_rdata", resp_rdata, e_rd);
                    got_rd  = resp_rdata;
                    got_err = resp_err;
                    resp_cnt++;
                end
            end
        end
    end

    // Derive the expected outcome of an accepted request from the access rules.
    task automatic model_accept(input logic ld, input logic st, input logic [2:0] f,
                                input logic [31:0] a, input logic [31:0] wd);
        int          size, off, t;
        logic [31:0] ea, w, v, mask;
        bit          legal, mis, err;
        t     = cyc;
        legal = (ld ^ st) && (ld ? (f == 3'b000 || f == 3'b001 || f == 3'b010 ||
                                    f == 3'b100 || f == 3'b101) : (f <= 3'b010));
        size  = 1 << f[1:0];
        mis   = (a % size) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
        err = !legal || mis;
`else
        err = !legal;
`endif
        ea    = a - (a % size);
        e_idx = int'((ea >> 2) % DEPTH);
        off   = int'(ea % 4);
        t_acc = t;
        e_rd  = 32'd0;
        e_err = 1'b0;
        e_re  = -1;
        e_we  = -1;
        if (err) begin
            e_err  = 1'b1;
            e_resp = t;
        end else if (ld) begin
            w = shadow[e_idx];
            v = w >> (8 * off);
            if (size == 1) begin
                v = v & 32'hFF;
                if (!f[2] && v[7]) v = v | 32'hFFFF_FF00;
            end else if (size == 2) begin
                v = v & 32'hFFFF;
                if (!f[2] && v[15]) v = v | 32'hFFFF_0000;
            end
            e_rd   = v;
            e_re   = t;
            e_resp = t + 2;
        end else if (size == 4) begin
            e_word = wd;
            e_we   = t;
            e_resp = t + 1;
        end else begin
            mask   = ((size == 1) ? 32'hFF : 32'hFFFF) << (8 * off);
            e_word = (shadow[e_idx] & ~mask) | ((wd << (8 * off)) & mask);
            e_re   = t;
            e_we   = t + 2;
            e_resp = t + 3;
        end
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] wd, output bit ok);
        int n;
        n = 0;
        ok = 1'b1;
        @(posedge clk); #2;
        while (!(reset && req_ready) && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 20) begin
            n_chk++;
            n_fail++;
            $display("FAIL ready_timeout: got req_ready=%0d expected 1 within 20 cycles", req_ready);
            ok = 1'b0;
            return;
        end
        req_valid = 1'b1;
        req_load  = ld;
        req_store = st;
        req_funct = f;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk); #1;
        model_accept(ld, st, f, a, wd);
        #1;
        req_valid = 1'b0;
        req_load  = 1'($urandom);
        req_store = 1'($urandom);
        req_funct = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic do_req(input logic ld, input logic st, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] wd, input string nm,
                          input bit lit, input logic [31:0] lit_rd, input logic lit_err);
        int n, prev;
        bit ok;
        prev = resp_cnt;
        issue(ld, st, f, a, wd, ok);
        if (!ok) return;
        n = 0;
        while (resp_cnt == prev && n < 12) begin
            @(posedge clk); #2;
            n++;
        end
        if (resp_cnt == prev) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_resp_timeout: got no resp_valid, expected one within 12 cycles", nm);
            return;
        end
        if (lit) begin
            chk({nm, "_rdata"}, got_rd, lit_rd);
            chk({nm, "_err"}, 32'(got_err), 32'(lit_err));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  pre_cnt;
        bit  ok;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_resp_err", 32'(resp_err), 32'd0);
        chk("reset_resp_rdata", resp_rdata, 32'd0);
        chk("reset_mem_re", 32'(mem_re), 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b1;
        @(posedge clk); #2;
        chk("ready_after_reset", 32'(req_ready), 32'd1);
        chk_en = 1'b1;

        do_req(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, "sw_10", 1'b1, 32'd0, 1'b0);
        chk("ram_w4_sw", ram[4], 32'hDEADBEEF);
        do_req(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, "lb_13", 1'b1, 32'hFFFFFFDE, 1'b0);
        do_req(1'b1, 1'b0, 3'b100, 32'h10, 32'h0, "lbu_10", 1'b1, 32'h000000EF, 1'b0);
        do_req(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, "lh_12", 1'b1, 32'hFFFFDEAD, 1'b0);
        do_req(1'b1, 1'b0, 3'b101, 32'h12, 32'h0, "lhu_12", 1'b1, 32'h0000DEAD, 1'b0);
        do_req(1'b1, 1'b0, 3'b010, 32'h1010, 32'h0, "lw_wrap", 1'b1, 32'hDEADBEEF, 1'b0);

        do_req(1'b0, 1'b1, 3'b010, 32'h20, 32'h11223344, "sw_20", 1'b1, 32'd0, 1'b0);
        do_req(1'b0, 1'b1, 3'b001, 32'h22, 32'h1234ABCD, "sh_22", 1'b1, 32'd0, 1'b0);
        chk("ram_w8_sh", ram[8], 32'hABCD3344);
        do_req(1'b0, 1'b1, 3'b000, 32'h21, 32'hFFFFFF7F, "sb_21", 1'b1, 32'd0, 1'b0);
        chk("ram_w8_sb", ram[8], 32'hABCD7F44);
        do_req(1'b1, 1'b0, 3'b001, 32'h20, 32'h0, "lh_20", 1'b1, 32'h00007F44, 1'b0);

`ifdef LSU_MISALIGN_TRAP_EN
        do_req(1'b1, 1'b0, 3'b010, 32'h22, 32'h0, "lw_mis", 1'b1, 32'd0, 1'b1);
        do_req(1'b1, 1'b0, 3'b001, 32'h23, 32'h0, "lh_mis", 1'b1, 32'd0, 1'b1);
        do_req(1'b0, 1'b1, 3'b010, 32'h21, 32'h0, "sw_mis", 1'b1, 32'd0, 1'b1);
`else
        do_req(1'b1, 1'b0, 3'b010, 32'h22, 32'h0, "lw_mis", 1'b1, 32'hABCD7F44, 1'b0);
        do_req(1'b1, 1'b0, 3'b001, 32'h23, 32'h0, "lh_mis", 1'b1, 32'hFFFFABCD, 1'b0);
`endif
        chk("ram_w8_after_mis", ram[8], 32'hABCD7F44);

        do_req(1'b1, 1'b1, 3'b010, 32'h10, 32'h0, "ill_both", 1'b1, 32'd0, 1'b1);
        do_req(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, "ill_none", 1'b1, 32'd0, 1'b1);
        do_req(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, "ill_lfunct", 1'b1, 32'd0, 1'b1);
        do_req(1'b0, 1'b1, 3'b100, 32'h10, 32'h5, "ill_sfunct", 1'b1, 32'd0, 1'b1);
        chk("ram_w4_after_ill", ram[4], 32'hDEADBEEF);

        // Abandon an RMW store by pulling reset low while the read word is sampled.
        pre_cnt = resp_cnt;
        issue(1'b0, 1'b1, 3'b000, 32'h21, 32'h00000055, ok);
        if (ok) begin
            @(posedge clk); #2;
            reset  = 1'b0;
            t_acc  = -1;
            e_re   = -1;
            e_we   = -1;
            e_resp = -1;
            @(posedge clk); #2;
            reset = 1'b1;
            @(posedge clk); #2;
            chk("ready_after_midrst", 32'(req_ready), 32'd1);
            repeat (3) @(posedge clk);
            #2;
            chk("ram_w8_after_midrst", ram[8], 32'hABCD7F44);
            chk("no_resp_after_midrst", 32'(resp_cnt), 32'(pre_cnt));
        end
        do_req(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, "lw_after_rst", 1'b1, 32'hABCD7F44, 1'b0);
        do_req(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, "lbu_13", 1'b1, 32'h000000DE, 1'b0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
